fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single framebuffer write port (sig_write/pixel/color)
//  of the video controller among NUM_REQ pixel writers (CPU store path, fill/blit engines).
//  Each requester uses a valid/ready handshake. One winner per cycle goes into a
//  registered output stage that drives the framebuffer write port.
// PARAMETERS
//  NUM_REQ    4       number of requesters, 2..8
//  FB_PIXELS  480000  framebuffer size in pixels (800x600); addresses 0..FB_PIXELS-1
// PORTS
//  clk         in   1            single clock domain; all logic on posedge clk
//  reset       in   1            synchronous, active-high
//  req_valid   in   NUM_REQ      requester i presents a write
//  req_ready   out  NUM_REQ      requester i write accepted this cycle (valid&ready)
//  req_pixel   in   NUM_REQ*20   packed linear pixel addresses, slice i = [20*i+:20]
//  req_color   in   NUM_REQ*24   packed RGB888 colours, slice i = [24*i+:24]
//  fb_ready    in   1            framebuffer accepts a write this cycle
//  sig_write   out  1            write strobe; a write occurs when sig_write & fb_ready
//  pixel       out  20           write address, registered
//  color       out  24           write data, registered
//  grant_id    out  3            index of the requester that produced the current output
//  drop_count  out  16           saturating count of dropped out-of-range writes
// BEHAVIOUR
//  - Reset (sync): sig_write=0, pixel=0, color=0, grant_id=0, drop_count=0, rr pointer=0.
//    Reset mid-transfer discards the held output. A write presented in the reset cycle is lost.
//  - Output stage: 1-entry register. out_free = ~sig_write | fb_ready.
//  - Arbitration, combinational each cycle: if out_free, grant the first i with req_valid[i],
//    searching from ptr up to NUM_REQ-1, then wrapping from 0 to ptr-1.
//    req_ready = onehot(grant) when out_free, else 0. At most one ready bit is set.
//  - On grant of i: next cycle sig_write=1, pixel/color = slice i, grant_id=i,
//    ptr <= (i+1) mod NUM_REQ. Request-to-strobe latency is exactly 1 cycle.
//  - No grant while out_free: sig_write <= 0. ptr unchanged.
//  - fb_ready=0 while sig_write=1: pixel/color/grant_id hold. No new grant.
//  - Throughput: 1 write/cycle while fb_ready=1 continuously (back-to-back accept and issue).
//  - Fairness: a continuously valid requester is granted within NUM_REQ grants.
//  - req_valid may drop without being granted. Data need only be stable in the grant cycle.
//  - ptr wrap: after granting NUM_REQ-1, ptr=0.
// CONFIGURATION
//  FB_WRITE_BOUNDS_CHECK_EN defined:
//    - A granted request with pixel >= FB_PIXELS is accepted (ready=1) but not issued.
//      sig_write <= 0 for that slot. ptr still advances.
//    - drop_count increments by 1 and saturates at 16'hFFFF.
//  Not defined:
//    - All addresses are forwarded unchanged. drop_count is tied to 0.
// STRUCTURE
//  - video_pkg holds: FB_WIDTH=800, FB_HEIGHT=600, FB_PIXELS, typedef logic[19:0]
//    pix_addr_t, typedef logic[23:0] rgb_t.
//  - Sub-module rr_arbiter (NUM_REQ, req, ptr -> onehot grant + index): pure combinational
//    priority rotate.
//  - The top level holds the ptr register, the output stage and the drop counter.
// TESTING
//  - Single req: req_valid=0001, pixel=5, color=FF0000, fb_ready=1
//    -> ready[0] same cycle; next cycle sig_write=1, pixel=5, color=FF0000, grant_id=0.
//  - All four valid continuously, fb_ready=1
//    -> grant order 0,1,2,3,0,...; one sig_write per cycle, no bubbles.
//  - Backpressure: fb_ready=0 for 3 cycles with output held
//    -> pixel/color stable, req_ready=0; on fb_ready=1 the next grant issues the following cycle.
//  - Wrap/fairness: ptr=3, req_valid=1001 -> grant 3, then 0. ptr=0 afterwards.
//  - Reset mid-stream: assert reset while sig_write=1, fb_ready=0
//    -> next cycle sig_write=0, ptr=0, drop_count=0.
//  - FB_WRITE_BOUNDS_CHECK_EN: pixel=480000 -> ready=1, no sig_write, drop_count=1;
//    pixel=479999 -> written. Without the macro, 480000 is forwarded.

Source files
------------

// File: rtl/video_pkg.sv
// Shared framebuffer geometry and pixel types for the video controller.
// Imported by the framebuffer write arbiter and its sub-blocks.
package video_pkg;

  localparam int FB_WIDTH  = 800;
  localparam int FB_HEIGHT = 600;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int ID_W      = 3;

  typedef logic [19:0] pix_addr_t;
  typedef logic [23:0] rgb_t;
  typedef logic [ID_W-1:0] req_id_t;

  function automatic req_id_t next_ptr(
    input req_id_t id,
    input int      n
  );
    if (int'(id) == n - 1) return '0;
    return id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester and framebuffer write-port bundle for fb_write_arbiter.
// The master side is the requester/framebuffer environment.
interface fb_write_arbiter_if
  import video_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*20-1:0] req_pixel;
  logic [NUM_REQ*24-1:0] req_color;
  logic                  fb_ready;
  logic                  sig_write;
  pix_addr_t             pixel;
  rgb_t                  color;
  req_id_t               grant_id;
  logic [15:0]           drop_count;

  modport master (
    output req_valid,
    output req_pixel,
    output req_color,
    output fb_ready,
    input  req_ready,
    input  sig_write,
    input  pixel,
    input  color,
    input  grant_id,
    input  drop_count
  );

  modport slave (
    input  req_valid,
    input  req_pixel,
    input  req_color,
    input  fb_ready,
    output req_ready,
    output sig_write,
    output pixel,
    output color,
    output grant_id,
    output drop_count
  );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin priority rotate: first request at or after
// ptr wins, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter
  import video_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] &&
            j == (int'(ptr) + k) % NUM_REQ) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = req_id_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin framebuffer write arbiter with a 1-entry output register.
// Define FB_WRITE_BOUNDS_CHECK_EN to drop and count out-of-range writes.
module fb_write_arbiter
  import video_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FB_PIXELS = video_pkg::FB_PIXELS
) (
  input logic               clk,
  input logic               reset,
  fb_write_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      FB_PIXELS < 1 || FB_PIXELS > (1 << 20)) begin : g_bad_cfg
    $error("fb_write_arbiter: bad parameters");
  end

  logic [NUM_REQ-1:0] grant;
  req_id_t            idx;
  req_id_t            ptr_q;
  logic               sig_write_q;
  pix_addr_t          pixel_q;
  rgb_t               color_q;
  req_id_t            grant_id_q;
  logic [15:0]        drop_q;

  logic      out_free;
  logic      any;
  logic      in_range;
  logic      issue;
  pix_addr_t sel_pixel;
  rgb_t      sel_color;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (idx)
  );

  assign out_free  = ~sig_write_q | bus.fb_ready;
  assign any       = |grant;
  assign sel_pixel = bus.req_pixel[int'(idx)*20 +: 20];
  assign sel_color = bus.req_color[int'(idx)*24 +: 24];

`ifdef FB_WRITE_BOUNDS_CHECK_EN
  assign in_range = int'(sel_pixel) < FB_PIXELS;
`else
  assign in_range = 1'b1;
`endif

  assign issue         = out_free & any & in_range;
  assign bus.req_ready = out_free ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      sig_write_q <= 1'b0;
      pixel_q     <= '0;
      color_q     <= '0;
      grant_id_q  <= '0;
    end else if (out_free) begin
      sig_write_q <= issue;
      if (issue) begin
        pixel_q    <= sel_pixel;
        color_q    <= sel_color;
        grant_id_q <= idx;
      end
      if (any) ptr_q <= next_ptr(idx, NUM_REQ);
    end
  end

`ifdef FB_WRITE_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (out_free && any && !in_range &&
                 drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  assign drop_q = '0;
`endif

  assign bus.sig_write  = sig_write_q;
  assign bus.pixel      = pixel_q;
  assign bus.color      = color_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: vector table plus scoreboard of issued writes.
// Expectations for FB_WRITE_BOUNDS_CHECK_EN follow the same macro.
module tb_fb_write_arbiter;
  import video_pkg::*;

  localparam int N = 4;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] valid;
    logic       fbr;
    logic [3:0] exp_ready;
    logic       exp_sw;
  } vec_t;

  typedef struct packed {
    logic [19:0] p;
    logic [23:0] c;
    logic [2:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [19:0] pix [N];
  logic [23:0] col [N];
  exp_t q [$];
  vec_t tbl [18];

  fb_write_arbiter_if #(.NUM_REQ(N)) bus ();

  fb_write_arbiter #(
    .NUM_REQ   (N),
    .FB_PIXELS (480000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) begin
      bus.req_pixel[20*i +: 20] = pix[i];
      bus.req_color[24*i +: 24] = col[i];
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cycle(input logic [3:0] v, input logic f,
                       input logic rst, input logic [3:0] er,
                       input logic esw, input string nm);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.req_valid = v;
    bus.fb_ready  = f;
    reset         = rst;
    set_data();
    #1;
    check({nm, ".ready"}, 32'(bus.req_ready), 32'(er));
    check({nm, ".sw"}, 32'(bus.sig_write), 32'(esw));
    if (bus.sig_write && f) begin
      if (q.size() == 0) begin
        check({nm, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        check({nm, ".pixel"}, 32'(bus.pixel), 32'(e.p));
        check({nm, ".color"}, 32'(bus.color), 32'(e.c));
        check({nm, ".gid"}, 32'(bus.grant_id), 32'(e.id));
      end
    end
    if (er != 4'b0) begin
      k = oh_idx(er);
      if (!(BCHK && pix[k] >= 20'd480000))
        q.push_back('{pix[k], col[k], 3'(k)});
    end
    if (rst) q.delete();
  endtask

  initial begin
    pix[0] = 20'd5;    col[0] = 24'hFF0000;
    pix[1] = 20'd1001; col[1] = 24'h00FF00;
    pix[2] = 20'd2002; col[2] = 24'h0000FF;
    pix[3] = 20'd3003; col[3] = 24'h123456;
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1};
    tbl[12] = '{4'b1001, 1'b1, 4'b0001, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b0};
    tbl[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.fb_ready  = 1'b1;
    set_data();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.sw", 32'(bus.sig_write), 32'(0));
    check("rst.pixel", 32'(bus.pixel), 32'(0));
    check("rst.color", 32'(bus.color), 32'(0));
    check("rst.gid", 32'(bus.grant_id), 32'(0));
    check("rst.drop", 32'(bus.drop_count), 32'(0));

    for (int i = 0; i < 18; i++)
      cycle(tbl[i].valid, tbl[i].fbr, 1'b0, tbl[i].exp_ready,
            tbl[i].exp_sw, $sformatf("v%0d", i));

    cycle(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, "mid_grant");
    cycle(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, "mid_rst");
    @(posedge clk);
    #1;
    check("mid.sw", 32'(bus.sig_write), 32'(0));
    check("mid.pixel", 32'(bus.pixel), 32'(0));
    check("mid.drop", 32'(bus.drop_count), 32'(0));
    cycle(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, "rst_ptr");
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, "drain");

    pix[1] = 20'd480000;
    pix[2] = 20'd479999;
    cycle(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, "oob_req");
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000, !BCHK, "oob_out");
    check("oob.drop", 32'(bus.drop_count), BCHK ? 32'(1) : 32'(0));
    cycle(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, "edge_req");
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, "edge_out");
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, "idle");
    check("sb.left", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
